axis_loopback_buf: RTL and testbench
====================================

AXIS_LOOPBACK_BUF -- requirements
Module: axis_loopback_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 256: TDATA width in bits; a multiple of 8; TSTRB width is DATA_W/8.
- DEPTH, 16: beat FIFO and metadata FIFO depth; a power of 2, at least 2.
- SWAP_PT, 0: when 1, SPT and DPT are exchanged on the loopback path.

REQ-002 Ports, one per line: name, direction, width, meaning. All single-clock.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- S_AXIS_DAT_TDATA  in  DATA_W  inbound beat data.
- S_AXIS_DAT_TVALID  in  1  inbound beat valid.
- S_AXIS_DAT_TSTRB  in  DATA_W/8  inbound byte strobes.
- S_AXIS_DAT_TLAST  in  1  inbound last beat of packet.
- S_AXIS_DAT_TREADY  out  1  inbound ready.
- S_AXIS_LEN_TDATA  in  16  packet length sideband.
- S_AXIS_SPT_TDATA  in  8  source port sideband.
- S_AXIS_DPT_TDATA  in  8  destination port sideband.
- S_AXIS_ERR_TDATA  in  1  error flag sideband.
- M_AXIS_DAT_TDATA, _TVALID, _TSTRB, _TLAST  out  matching S widths  outbound beat.
- M_AXIS_DAT_TREADY  in  1  outbound ready.
- M_AXIS_LEN_TDATA, _SPT_TDATA, _DPT_TDATA, _ERR_TDATA  out  16/8/8/1  outbound sideband.
- STAT_PKT_CNT  out  32  outbound packet count.
- STAT_STALL_CNT  out  32  outbound stall-cycle count.

Function
REQ-003 Handshakes: beat moves on TVALID&&TREADY; S_AXIS_DAT_TREADY shall be registered and equal (beat count != DEPTH), with no combinational path from M_AXIS_DAT_TREADY.
REQ-004 Beat FIFO: stores {TDATA,TSTRB,TLAST}; accepted beat visible on M no earlier than 1 cycle after acceptance; full throughput is 1 beat/cycle, preserving order.
REQ-005 Full: a pop in the same cycle as full shall not enable a push that cycle; TREADY rises the following cycle.
REQ-006 Empty: M_AXIS_DAT_TVALID=0; simultaneous push and pop on a 1-entry FIFO keeps count unchanged.
REQ-007 Input FSM, states IN_IDLE and IN_PKT:
- IN_IDLE->IN_PKT on a non-last accepted beat.
- IN_PKT->IN_IDLE on an accepted TLAST.
- A single-beat packet (TLAST on first beat) stays IN_IDLE.
REQ-008 Metadata capture: on every accepted beat in IN_IDLE (first beat), push {LEN, SPT, DPT, ERR} into the metadata FIFO; S-side sideband is ignored on all other beats.
REQ-009 Metadata FIFO: holds DEPTH entries; it never overflows, since each packet occupies at least one beat entry.
REQ-010 Output sideband:
- M_AXIS_LEN/SPT/DPT/ERR shall equal the metadata FIFO head whenever M_AXIS_DAT_TVALID=1, held stable for all beats of that packet.
- The metadata head shall pop on M TLAST handshake.
- Value is 0 when the metadata FIFO is empty.
REQ-011 SWAP_PT=1: M_AXIS_SPT_TDATA=stored DPT and M_AXIS_DPT_TDATA=stored SPT; SWAP_PT=0 is pass-through.
REQ-012 Sideband gating: M_AXIS_DAT_TVALID shall be asserted only when both the beat FIFO and the metadata FIFO are non-empty.
REQ-013 Cut-through: no store-and-forward; packets longer than DEPTH stream without deadlock.

Reset
REQ-014 ARESETN low shall asynchronously clear:
- both FIFO pointers and counts;
- input FSM to IN_IDLE;
- S_AXIS_DAT_TREADY=0, M_AXIS_DAT_TVALID=0, all M outputs 0;
- stats counters 0.
REQ-015 Release: S_AXIS_DAT_TREADY=1 on the first ACLK edge after ARESETN deasserts.
REQ-016 Reset mid-packet: discards all buffered beats and metadata; the next S beat is treated as a first beat.

Configuration
REQ-017 Macro AXIS_LOOPBACK_BUF_STATS_EN, when defined:
- STAT_PKT_CNT increments on each M TLAST handshake and wraps modulo 2^32.
- STAT_STALL_CNT increments each cycle with M_AXIS_DAT_TVALID=1 and M_AXIS_DAT_TREADY=0, saturating at 0xFFFFFFFF.
REQ-018 Macro undefined: both stats ports are constant 0 and no counter logic is compiled.

Verification
REQ-019 Single beat: LEN=0x0020, SPT=0x03, DPT=0x07, ERR=0, TLAST=1, M_TREADY=1 -> M beat with identical TDATA/TSTRB 1 cycle later; sideband 0x0020/0x03/0x07/0.
REQ-020 Swap: same stimulus with SWAP_PT=1 -> M SPT=0x07, DPT=0x03.
REQ-021 Full: hold M_TREADY=0, send 20 beats, DEPTH=16 -> S_TREADY=0 after the 16th accept; release M_TREADY -> 20 beats out in order, no loss or duplication.
REQ-022 Sideband latch: 3 packets (4, 1, 40 beats) with sideband changing every beat -> each M packet carries its first-beat sideband, constant across all its beats.
REQ-023 Reset mid-packet: assert ARESETN low during beat 5 of 10 -> M_TVALID=0 immediately; after release, a new 2-beat packet loops back with its own sideband.
REQ-024 Stats (macro defined): 5 packets plus 7 stalled cycles -> STAT_PKT_CNT=5, STAT_STALL_CNT=7. Same stimulus, macro undefined -> both stats ports 0.

Source files
------------

// File: rtl/axis_loopback_buf.sv
// AXI-Stream loopback buffer: cut-through beat FIFO plus a per-packet sideband FIFO.
// Optional statistics counters are compiled in when AXIS_LOOPBACK_BUF_STATS_EN is defined.
module axis_loopback_buf #(
  parameter int DATA_W  = 256,
  parameter int DEPTH   = 16,
  parameter bit SWAP_PT = 1'b0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [DATA_W-1:0]   S_AXIS_DAT_TDATA,
  input  logic                S_AXIS_DAT_TVALID,
  input  logic [DATA_W/8-1:0] S_AXIS_DAT_TSTRB,
  input  logic                S_AXIS_DAT_TLAST,
  output logic                S_AXIS_DAT_TREADY,
  input  logic [15:0]         S_AXIS_LEN_TDATA,
  input  logic [7:0]          S_AXIS_SPT_TDATA,
  input  logic [7:0]          S_AXIS_DPT_TDATA,
  input  logic                S_AXIS_ERR_TDATA,
  output logic [DATA_W-1:0]   M_AXIS_DAT_TDATA,
  output logic                M_AXIS_DAT_TVALID,
  output logic [DATA_W/8-1:0] M_AXIS_DAT_TSTRB,
  output logic                M_AXIS_DAT_TLAST,
  input  logic                M_AXIS_DAT_TREADY,
  output logic [15:0]         M_AXIS_LEN_TDATA,
  output logic [7:0]          M_AXIS_SPT_TDATA,
  output logic [7:0]          M_AXIS_DPT_TDATA,
  output logic                M_AXIS_ERR_TDATA,
  output logic [31:0]         STAT_PKT_CNT,
  output logic [31:0]         STAT_STALL_CNT
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  spt;
    logic [7:0]  dpt;
    logic        err;
  } meta_t;

  typedef enum logic {IN_IDLE, IN_PKT} in_state_e;

  beat_t         beat_mem_q [DEPTH];
  meta_t         meta_mem_q [DEPTH];
  logic [AW-1:0] beat_wr_q, beat_rd_q, meta_wr_q, meta_rd_q;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, meta_cnt_q, meta_cnt_d;
  logic          s_tready_q;
  in_state_e     in_state_q;

  logic  s_push, meta_push, m_valid, m_pop, meta_pop, beat_ne, meta_ne;
  beat_t beat_head;
  meta_t meta_head;

  assign s_push    = S_AXIS_DAT_TVALID && s_tready_q;
  assign meta_push = s_push && (in_state_q == IN_IDLE);
  assign beat_ne   = (beat_cnt_q != '0);
  assign meta_ne   = (meta_cnt_q != '0);
  assign m_valid   = beat_ne && meta_ne;
  assign m_pop     = m_valid && M_AXIS_DAT_TREADY;
  assign beat_head = beat_mem_q[beat_rd_q];
  assign meta_head = meta_mem_q[meta_rd_q];
  assign meta_pop  = m_pop && beat_head.last;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    meta_cnt_d = meta_cnt_q;
    case ({s_push, m_pop})
      2'b10:   beat_cnt_d = beat_cnt_q + CNT_ONE;
      2'b01:   beat_cnt_d = beat_cnt_q - CNT_ONE;
      default: ;
    endcase
    case ({meta_push, meta_pop})
      2'b10:   meta_cnt_d = meta_cnt_q + CNT_ONE;
      2'b01:   meta_cnt_d = meta_cnt_q - CNT_ONE;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_wr_q  <= '0;
      beat_rd_q  <= '0;
      meta_wr_q  <= '0;
      meta_rd_q  <= '0;
      beat_cnt_q <= '0;
      meta_cnt_q <= '0;
      s_tready_q <= 1'b0;
    end else begin
      if (s_push)    beat_wr_q <= beat_wr_q + PTR_ONE;
      if (m_pop)     beat_rd_q <= beat_rd_q + PTR_ONE;
      if (meta_push) meta_wr_q <= meta_wr_q + PTR_ONE;
      if (meta_pop)  meta_rd_q <= meta_rd_q + PTR_ONE;
      beat_cnt_q <= beat_cnt_d;
      meta_cnt_q <= meta_cnt_d;
      // Ready is looked ahead from the next count, so a pop while full frees space one cycle later.
      s_tready_q <= (beat_cnt_d != FULL_CNT);
    end
  end

  // Sideband is only sampled on a packet's first beat; the FSM tracks where packets start.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in_state_q <= IN_IDLE;
    end else if (s_push) begin
      case (in_state_q)
        IN_IDLE: if (!S_AXIS_DAT_TLAST) in_state_q <= IN_PKT;
        IN_PKT:  if (S_AXIS_DAT_TLAST)  in_state_q <= IN_IDLE;
        default: in_state_q <= IN_IDLE;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; validity is tracked solely by the counts.
  always_ff @(posedge ACLK) begin
    if (s_push) begin
      beat_mem_q[beat_wr_q] <= {S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TLAST};
    end
    if (meta_push) begin
      meta_mem_q[meta_wr_q] <= {S_AXIS_LEN_TDATA, S_AXIS_SPT_TDATA,
                                S_AXIS_DPT_TDATA, S_AXIS_ERR_TDATA};
    end
  end

  assign S_AXIS_DAT_TREADY = s_tready_q;
  assign M_AXIS_DAT_TVALID = m_valid;
  assign M_AXIS_DAT_TDATA  = m_valid ? beat_head.data : '0;
  assign M_AXIS_DAT_TSTRB  = m_valid ? beat_head.strb : '0;
  assign M_AXIS_DAT_TLAST  = m_valid && beat_head.last;

  assign M_AXIS_LEN_TDATA  = meta_ne ? meta_head.len : '0;
  assign M_AXIS_SPT_TDATA  = meta_ne ? (SWAP_PT ? meta_head.dpt : meta_head.spt) : '0;
  assign M_AXIS_DPT_TDATA  = meta_ne ? (SWAP_PT ? meta_head.spt : meta_head.dpt) : '0;
  assign M_AXIS_ERR_TDATA  = meta_ne && meta_head.err;

`ifdef AXIS_LOOPBACK_BUF_STATS_EN
  logic [31:0] pkt_cnt_q, stall_cnt_q;

  // Packet count wraps; stall count saturates so long stalls never look short.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (meta_pop) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (m_valid && !M_AXIS_DAT_TREADY && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign STAT_PKT_CNT   = pkt_cnt_q;
  assign STAT_STALL_CNT = stall_cnt_q;
`else
  assign STAT_PKT_CNT   = '0;
  assign STAT_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_axis_loopback_buf.sv
// Scoreboard bench for axis_loopback_buf: driver pushes expected beats, a monitor pops and compares.
// A second instance with SWAP_PT=1 shares all inputs and is checked against the same expectations.
`timescale 1ns/1ps
module tb_axis_loopback_buf;

  localparam int DATA_W = 256;
  localparam int STRB_W = DATA_W / 8;

  logic              ACLK    = 1'b0;
  logic              ARESETN = 1'b0;
  logic [DATA_W-1:0] S_AXIS_DAT_TDATA  = '0;
  logic              S_AXIS_DAT_TVALID = 1'b0;
  logic [STRB_W-1:0] S_AXIS_DAT_TSTRB  = '0;
  logic              S_AXIS_DAT_TLAST  = 1'b0;
  logic              S_AXIS_DAT_TREADY;
  logic [15:0]       S_AXIS_LEN_TDATA  = '0;
  logic [7:0]        S_AXIS_SPT_TDATA  = '0;
  logic [7:0]        S_AXIS_DPT_TDATA  = '0;
  logic              S_AXIS_ERR_TDATA  = 1'b0;
  logic [DATA_W-1:0] M_AXIS_DAT_TDATA;
  logic              M_AXIS_DAT_TVALID;
  logic [STRB_W-1:0] M_AXIS_DAT_TSTRB;
  logic              M_AXIS_DAT_TLAST;
  logic              M_AXIS_DAT_TREADY;
  logic [15:0]       M_AXIS_LEN_TDATA;
  logic [7:0]        M_AXIS_SPT_TDATA;
  logic [7:0]        M_AXIS_DPT_TDATA;
  logic              M_AXIS_ERR_TDATA;
  logic [31:0]       STAT_PKT_CNT;
  logic [31:0]       STAT_STALL_CNT;

  logic              s1_tready;
  logic [DATA_W-1:0] m1_tdata;
  logic              m1_tvalid;
  logic [STRB_W-1:0] m1_tstrb;
  logic              m1_tlast;
  logic [15:0]       m1_len;
  logic [7:0]        m1_spt;
  logic [7:0]        m1_dpt;
  logic              m1_err;
  logic [31:0]       m1_stat_pkt;
  logic [31:0]       m1_stat_stall;

  axis_loopback_buf #(.DATA_W(DATA_W), .DEPTH(16), .SWAP_PT(1'b0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_DAT_TDATA(S_AXIS_DAT_TDATA), .S_AXIS_DAT_TVALID(S_AXIS_DAT_TVALID),
    .S_AXIS_DAT_TSTRB(S_AXIS_DAT_TSTRB), .S_AXIS_DAT_TLAST(S_AXIS_DAT_TLAST),
    .S_AXIS_DAT_TREADY(S_AXIS_DAT_TREADY),
    .S_AXIS_LEN_TDATA(S_AXIS_LEN_TDATA), .S_AXIS_SPT_TDATA(S_AXIS_SPT_TDATA),
    .S_AXIS_DPT_TDATA(S_AXIS_DPT_TDATA), .S_AXIS_ERR_TDATA(S_AXIS_ERR_TDATA),
    .M_AXIS_DAT_TDATA(M_AXIS_DAT_TDATA), .M_AXIS_DAT_TVALID(M_AXIS_DAT_TVALID),
    .M_AXIS_DAT_TSTRB(M_AXIS_DAT_TSTRB), .M_AXIS_DAT_TLAST(M_AXIS_DAT_TLAST),
    .M_AXIS_DAT_TREADY(M_AXIS_DAT_TREADY),
    .M_AXIS_LEN_TDATA(M_AXIS_LEN_TDATA), .M_AXIS_SPT_TDATA(M_AXIS_SPT_TDATA),
    .M_AXIS_DPT_TDATA(M_AXIS_DPT_TDATA), .M_AXIS_ERR_TDATA(M_AXIS_ERR_TDATA),
    .STAT_PKT_CNT(STAT_PKT_CNT), .STAT_STALL_CNT(STAT_STALL_CNT)
  );

  axis_loopback_buf #(.DATA_W(DATA_W), .DEPTH(16), .SWAP_PT(1'b1)) dut_swap (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_DAT_TDATA(S_AXIS_DAT_TDATA), .S_AXIS_DAT_TVALID(S_AXIS_DAT_TVALID),
    .S_AXIS_DAT_TSTRB(S_AXIS_DAT_TSTRB), .S_AXIS_DAT_TLAST(S_AXIS_DAT_TLAST),
    .S_AXIS_DAT_TREADY(s1_tready),
    .S_AXIS_LEN_TDATA(S_AXIS_LEN_TDATA), .S_AXIS_SPT_TDATA(S_AXIS_SPT_TDATA),
    .S_AXIS_DPT_TDATA(S_AXIS_DPT_TDATA), .S_AXIS_ERR_TDATA(S_AXIS_ERR_TDATA),
    .M_AXIS_DAT_TDATA(m1_tdata), .M_AXIS_DAT_TVALID(m1_tvalid),
    .M_AXIS_DAT_TSTRB(m1_tstrb), .M_AXIS_DAT_TLAST(m1_tlast),
    .M_AXIS_DAT_TREADY(M_AXIS_DAT_TREADY),
    .M_AXIS_LEN_TDATA(m1_len), .M_AXIS_SPT_TDATA(m1_spt),
    .M_AXIS_DPT_TDATA(m1_dpt), .M_AXIS_ERR_TDATA(m1_err),
    .STAT_PKT_CNT(m1_stat_pkt), .STAT_STALL_CNT(m1_stat_stall)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [15:0]       len;
    logic [7:0]        spt;
    logic [7:0]        dpt;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_rx     = 0;
  bit   bp_en    = 1'b0;
  logic mready_fixed = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Single writer of the outbound ready: random backpressure or a fixed level.
  initial begin
    M_AXIS_DAT_TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #2;
      M_AXIS_DAT_TREADY = bp_en ? ($urandom_range(0, 3) != 0) : mready_fixed;
    end
  end

  // Monitor: every outbound handshake pops one expected beat.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (M_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY) begin
        check("m_beat_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_tdata", M_AXIS_DAT_TDATA, e.data);
          check("m_tstrb", 256'(M_AXIS_DAT_TSTRB), 256'(e.strb));
          check("m_tlast", 256'(M_AXIS_DAT_TLAST), 256'(e.last));
          check("m_len",   256'(M_AXIS_LEN_TDATA), 256'(e.len));
          check("m_spt",   256'(M_AXIS_SPT_TDATA), 256'(e.spt));
          check("m_dpt",   256'(M_AXIS_DPT_TDATA), 256'(e.dpt));
          check("m_err",   256'(M_AXIS_ERR_TDATA), 256'(e.err));
          check("swap_tvalid", 256'(m1_tvalid), 256'(1));
          check("swap_tdata",  m1_tdata, e.data);
          check("swap_len",    256'(m1_len), 256'(e.len));
          check("swap_spt",    256'(m1_spt), 256'(e.dpt));
          check("swap_dpt",    256'(m1_dpt), 256'(e.spt));
        end
        n_rx++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input exp_t drv, input exp_t exp);
    int n = 0;
    S_AXIS_DAT_TDATA  = drv.data;
    S_AXIS_DAT_TSTRB  = drv.strb;
    S_AXIS_DAT_TLAST  = drv.last;
    S_AXIS_LEN_TDATA  = drv.len;
    S_AXIS_SPT_TDATA  = drv.spt;
    S_AXIS_DPT_TDATA  = drv.dpt;
    S_AXIS_ERR_TDATA  = drv.err;
    S_AXIS_DAT_TVALID = 1'b1;
    do begin
      @(negedge ACLK);
      n++;
    end while (!S_AXIS_DAT_TREADY && n < 2000);
    if (S_AXIS_DAT_TREADY) begin
      exp_q.push_back(exp);
      n_acc++;
    end else begin
      check("s_accept_timeout", 256'(S_AXIS_DAT_TREADY), 256'(1));
    end
    @(posedge ACLK);
    #1;
  endtask

  // Every beat carries its own random sideband when chg_sb is set; only the first beat's counts.
  task automatic send_pkt(input int nbeats, input logic [15:0] len, input logic [7:0] spt,
                          input logic [7:0] dpt, input logic err, input bit chg_sb, input bit gaps);
    exp_t drv, exp;
    for (int i = 0; i < nbeats; i++) begin
      drv.data = rand_data();
      drv.strb = $urandom();
      drv.last = (i == nbeats - 1);
      if (i == 0 || !chg_sb) begin
        drv.len = len; drv.spt = spt; drv.dpt = dpt; drv.err = err;
      end else begin
        drv.len = 16'($urandom()); drv.spt = 8'($urandom());
        drv.dpt = 8'($urandom());  drv.err = 1'($urandom());
      end
      exp = drv;
      exp.len = len; exp.spt = spt; exp.dpt = dpt; exp.err = err;
      send_beat(drv, exp);
      if (gaps && (i != nbeats - 1) && ($urandom_range(0, 3) == 0)) begin
        S_AXIS_DAT_TVALID = 1'b0;
        @(posedge ACLK);
        #1;
      end
    end
    S_AXIS_DAT_TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge ACLK);
      n++;
    end
    check("drain_queue_empty", 256'(exp_q.size()), 256'(0));
    repeat (2) @(posedge ACLK);
    #1;
    check("idle_tvalid", 256'(M_AXIS_DAT_TVALID), 256'(0));
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    S_AXIS_DAT_TVALID = 1'b0;
    #1;
    check("rst_tvalid", 256'(M_AXIS_DAT_TVALID), 256'(0));
    check("rst_tready", 256'(S_AXIS_DAT_TREADY), 256'(0));
    exp_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  initial begin : main
    int base_acc, base_rx, n;
    exp_t drv;
    logic [31:0] exp_pkt, exp_stall;

    // Reset state and release timing.
    #12;
    check("reset_tready",     256'(S_AXIS_DAT_TREADY), 256'(0));
    check("reset_tvalid",     256'(M_AXIS_DAT_TVALID), 256'(0));
    check("reset_tdata",      M_AXIS_DAT_TDATA, 256'(0));
    check("reset_tlast",      256'(M_AXIS_DAT_TLAST), 256'(0));
    check("reset_len",        256'(M_AXIS_LEN_TDATA), 256'(0));
    check("reset_spt",        256'(M_AXIS_SPT_TDATA), 256'(0));
    check("reset_stat_pkt",   256'(STAT_PKT_CNT), 256'(0));
    check("reset_stat_stall", 256'(STAT_STALL_CNT), 256'(0));
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    check("release_tready_before_edge", 256'(S_AXIS_DAT_TREADY), 256'(0));
    @(posedge ACLK);
    #1;
    check("release_tready_first_edge", 256'(S_AXIS_DAT_TREADY), 256'(1));

    // Single-beat packet with fixed sideband; swap instance checked in the monitor.
    mready_fixed = 1'b1;
    @(posedge ACLK);
    #1;
    check("single_pre_tvalid", 256'(M_AXIS_DAT_TVALID), 256'(0));
    send_pkt(1, 16'h0020, 8'h03, 8'h07, 1'b0, 1'b0, 1'b0);
    check("single_latency_tvalid", 256'(M_AXIS_DAT_TVALID), 256'(1));
    wait_drain();

    // Fill to full with output blocked, then release.
    mready_fixed = 1'b0;
    @(posedge ACLK);
    #1;
    base_acc = n_acc;
    base_rx  = n_rx;
    fork
      send_pkt(20, 16'h1234, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
      begin
        n = 0;
        while (n_acc < base_acc + 16 && n < 3000) begin
          @(posedge ACLK);
          n++;
        end
        #1;
        check("full_accepted",   256'(n_acc - base_acc), 256'(16));
        check("full_tready_low", 256'(S_AXIS_DAT_TREADY), 256'(0));
        repeat (4) @(posedge ACLK);
        #1;
        check("full_tready_held", 256'(S_AXIS_DAT_TREADY), 256'(0));
        check("full_accept_held", 256'(n_acc - base_acc), 256'(16));
        check("full_tvalid",      256'(M_AXIS_DAT_TVALID), 256'(1));
        mready_fixed = 1'b1;
        check("full_tready_pop_cycle", 256'(S_AXIS_DAT_TREADY), 256'(0));
        @(posedge ACLK);
        #1;
        check("full_tready_recover", 256'(S_AXIS_DAT_TREADY), 256'(1));
      end
    join
    wait_drain();
    check("full_beats_out", 256'(n_rx - base_rx), 256'(20));

    // Sideband latch across 4, 1 and 40 beat packets under backpressure.
    bp_en = 1'b1;
    send_pkt(4,  16'h0004, 8'hA1, 8'hB1, 1'b0, 1'b1, 1'b0);
    send_pkt(1,  16'h0001, 8'hA2, 8'hB2, 1'b1, 1'b1, 1'b0);
    send_pkt(40, 16'h0028, 8'hA3, 8'hB3, 1'b0, 1'b1, 1'b0);
    bp_en = 1'b0;
    wait_drain();

    // Randomised packets, gaps and backpressure.
    bp_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      send_pkt($urandom_range(1, 24), 16'($urandom()), 8'($urandom()), 8'($urandom()),
               1'($urandom()), 1'($urandom()), 1'b1);
    end
    bp_en = 1'b0;
    wait_drain();

    // Reset in the middle of a 10-beat packet.
    mready_fixed = 1'b0;
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      drv.data = rand_data(); drv.strb = $urandom(); drv.last = 1'b0;
      drv.len = 16'h000A; drv.spt = 8'h55; drv.dpt = 8'h66; drv.err = 1'b0;
      send_beat(drv, drv);
    end
    check("mid_tvalid_before", 256'(M_AXIS_DAT_TVALID), 256'(1));
    S_AXIS_DAT_TDATA = rand_data();
    S_AXIS_DAT_TVALID = 1'b1;
    #2;
    ARESETN = 1'b0;
    #1;
    check("mid_rst_tvalid", 256'(M_AXIS_DAT_TVALID), 256'(0));
    check("mid_rst_tready", 256'(S_AXIS_DAT_TREADY), 256'(0));
    check("mid_rst_tdata",  M_AXIS_DAT_TDATA, 256'(0));
    check("mid_rst_len",    256'(M_AXIS_LEN_TDATA), 256'(0));
    exp_q.delete();
    S_AXIS_DAT_TVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    mready_fixed = 1'b1;
    base_rx = n_rx;
    send_pkt(2, 16'h0123, 8'h45, 8'h67, 1'b1, 1'b1, 1'b0);
    wait_drain();
    check("mid_new_pkt_beats", 256'(n_rx - base_rx), 256'(2));

    // Statistics: 5 packets, exactly 7 stalled cycles on the first one.
    mready_fixed = 1'b0;
    do_reset();
    check("stats_cleared", 256'({STAT_PKT_CNT, STAT_STALL_CNT}), 256'(0));
    send_pkt(1, 16'h0001, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge ACLK);
    #1;
    mready_fixed = 1'b1;
    for (int p = 0; p < 4; p++) begin
      send_pkt(2, 16'($urandom()), 8'($urandom()), 8'($urandom()), 1'b0, 1'b1, 1'b0);
    end
    wait_drain();
`ifdef AXIS_LOOPBACK_BUF_STATS_EN
    exp_pkt   = 32'd5;
    exp_stall = 32'd7;
`else
    exp_pkt   = 32'd0;
    exp_stall = 32'd0;
`endif
    check("stat_pkt_cnt",   256'(STAT_PKT_CNT), 256'(exp_pkt));
    check("stat_stall_cnt", 256'(STAT_STALL_CNT), 256'(exp_stall));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
